// File: rtl/scpu_spi_rx_pkg.sv
// scpu_spi_rx shared types: receiver state encoding and ERR_CODE values.
// Ports: none (package only).
package scpu_spi_rx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAP  = 2'd1,
    S_SHF  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_LEN   = 2'b01;
  localparam logic [1:0] ERR_PHASE = 2'b10;
  localparam logic [1:0] ERR_OVLP  = 2'b11;

endpackage

// File: rtl/scpu_spi_rx_edge.sv
// Link input sampler: optional 2-flop sync (SCPU_SPI_RX_SYNC_EN), r1/r2, rise.
// Ports: clk, rst_n, i_d (raw link input), o_lvl (r1 level), o_rise (r1 & ~r2).
module scpu_spi_rx_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise
);

  logic w_in;
  logic r1;
  logic r2;

`ifdef SCPU_SPI_RX_SYNC_EN
  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= i_d;
      r_s1 <= r_s0;
    end
  end

  assign w_in = r_s1;
`else
  assign w_in = i_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
    end else begin
      r1 <= w_in;
      r2 <= r1;
    end
  end

  assign o_lvl  = r1;
  assign o_rise = r1 & ~r2;

endmodule

// File: rtl/scpu_spi_rx.sv
// SCPU analog-config link receiver: two-phase deserializer, LAT-framed words.
// Ports: CLK, RST_N, SPI_SI, SCLK1, SCLK2, LAT, ERR_CLR in; DATA_OUT, DATA_VLD,
// BUSY, FRAME_ERR, ERR_CODE out. Optional SCPU_SPI_RX_SYNC_EN adds input sync.
module scpu_spi_rx
  import scpu_spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  SPI_SI,
  input  logic                  SCLK1,
  input  logic                  SCLK2,
  input  logic                  LAT,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VLD,
  output logic                  BUSY,
  output logic                  FRAME_ERR,
  output logic [1:0]            ERR_CODE
);

  localparam int CW = $clog2(DATA_WIDTH + 2);
  localparam logic [CW-1:0] C_FULL = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] C_SAT  = CW'(DATA_WIDTH + 1);

  logic w_s1_lvl, w_s1_rise;
  logic w_s2_lvl, w_s2_rise;
  logic w_lat_rise, w_unused_lat_lvl;
  logic w_si_in;
  logic r_si;

  scpu_spi_rx_edge u_s1 (
    .clk(CLK), .rst_n(RST_N), .i_d(SCLK1),
    .o_lvl(w_s1_lvl), .o_rise(w_s1_rise)
  );

  scpu_spi_rx_edge u_s2 (
    .clk(CLK), .rst_n(RST_N), .i_d(SCLK2),
    .o_lvl(w_s2_lvl), .o_rise(w_s2_rise)
  );

  scpu_spi_rx_edge u_lat (
    .clk(CLK), .rst_n(RST_N), .i_d(LAT),
    .o_lvl(w_unused_lat_lvl), .o_rise(w_lat_rise)
  );

`ifdef SCPU_SPI_RX_SYNC_EN
  logic r_si_s0;
  logic r_si_s1;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_si_s0 <= 1'b0;
      r_si_s1 <= 1'b0;
    end else begin
      r_si_s0 <= SPI_SI;
      r_si_s1 <= r_si_s0;
    end
  end

  assign w_si_in = r_si_s1;
`else
  assign w_si_in = SPI_SI;
`endif

  // Data level aligned with the r1 stage of SCLK1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_si <= 1'b0;
    else        r_si <= w_si_in;
  end

  state_t                r_state, w_state_nx;
  logic                  r_master, w_master_nx;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [DATA_WIDTH-1:0] r_data, w_data_nx;
  logic                  r_vld, w_vld;
  logic                  r_ferr;
  logic [1:0]            r_code;

  logic                  w_err;
  logic [1:0]            w_code;
  logic                  w_lat_go;
  logic [DATA_WIDTH-1:0] w_sh_data;
  logic [CW-1:0]         w_sh_cnt;
  logic [DATA_WIDTH-1:0] w_lat_data;
  logic [CW-1:0]         w_lat_cnt;
  logic                  w_ovlp;

  assign w_ovlp    = w_s1_lvl & w_s2_lvl;
  assign w_sh_data = {r_shift[DATA_WIDTH-2:0], r_master};
  assign w_sh_cnt  = (r_cnt == C_SAT) ? r_cnt : r_cnt + CW'(1);

  // A LAT coincident with the final SCLK2 sees the post-shift frame.
  assign w_lat_data = (r_state == S_CAP) ? w_sh_data : r_shift;
  assign w_lat_cnt  = (r_state == S_CAP) ? w_sh_cnt  : r_cnt;

  always_comb begin
    w_state_nx  = r_state;
    w_master_nx = r_master;
    w_shift_nx  = r_shift;
    w_cnt_nx    = r_cnt;
    w_data_nx   = r_data;
    w_vld       = 1'b0;
    w_err       = 1'b0;
    w_code      = ERR_NONE;
    w_lat_go    = 1'b0;
    if (w_ovlp && r_state != S_DROP) begin
      w_err      = 1'b1;
      w_code     = ERR_OVLP;
      w_state_nx = S_DROP;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_s1_rise) begin
            w_master_nx = r_si;
            w_state_nx  = S_CAP;
          end else if (w_s2_rise) begin
            w_err      = 1'b1;
            w_code     = ERR_PHASE;
            w_state_nx = S_DROP;
          end
        end
        S_CAP: begin
          if (w_s1_rise) begin
            w_err      = 1'b1;
            w_code     = ERR_PHASE;
            w_state_nx = S_DROP;
          end else if (w_s2_rise) begin
            w_shift_nx = w_sh_data;
            w_cnt_nx   = w_sh_cnt;
            w_state_nx = S_SHF;
            w_lat_go   = w_lat_rise;
          end else if (w_lat_rise) begin
            w_err      = 1'b1;
            w_code     = ERR_LEN;
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end
        end
        S_SHF: begin
          if (w_s1_rise) begin
            w_master_nx = r_si;
            w_state_nx  = S_CAP;
          end else if (w_s2_rise) begin
            w_err      = 1'b1;
            w_code     = ERR_PHASE;
            w_state_nx = S_DROP;
          end else begin
            w_lat_go = w_lat_rise;
          end
        end
        S_DROP: begin
          if (w_lat_rise) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
          end
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
    if (w_lat_go) begin
      if (w_lat_cnt == C_FULL) begin
        w_vld     = 1'b1;
        w_data_nx = w_lat_data;
      end else begin
        w_err  = 1'b1;
        w_code = ERR_LEN;
      end
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_master <= 1'b0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_vld    <= 1'b0;
      r_ferr   <= 1'b0;
      r_code   <= ERR_NONE;
    end else begin
      r_state  <= w_state_nx;
      r_master <= w_master_nx;
      r_shift  <= w_shift_nx;
      r_cnt    <= w_cnt_nx;
      r_data   <= w_data_nx;
      r_vld    <= w_vld;
      // First error since clear is held; a new error beats a same-cycle clear.
      if (w_err) begin
        r_ferr <= 1'b1;
        if (!r_ferr || ERR_CLR) r_code <= w_code;
      end else if (ERR_CLR) begin
        r_ferr <= 1'b0;
        r_code <= ERR_NONE;
      end
    end
  end

  assign DATA_OUT  = r_data;
  assign DATA_VLD  = r_vld;
  assign BUSY      = (r_state != S_IDLE);
  assign FRAME_ERR = r_ferr;
  assign ERR_CODE  = r_code;

endmodule

// File: tb/tb_scpu_spi_rx.sv
// Directed self-checking bench for scpu_spi_rx (16-bit frames).
// Honors SCPU_SPI_RX_SYNC_EN for the expected DATA_VLD latency.
module tb_scpu_spi_rx;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        SPI_SI;
  logic        SCLK1;
  logic        SCLK2;
  logic        LAT;
  logic        ERR_CLR;
  logic [15:0] DATA_OUT;
  logic        DATA_VLD;
  logic        BUSY;
  logic        FRAME_ERR;
  logic [1:0]  ERR_CODE;

  int checks = 0;
  int errors = 0;
  int vld_wide = 0;
  logic prev_vld = 1'b0;
  int at;
  int nv;

`ifdef SCPU_SPI_RX_SYNC_EN
  localparam int EXP_LAT = 4;
`else
  localparam int EXP_LAT = 2;
`endif

  always #5 CLK = ~CLK;

  scpu_spi_rx #(.DATA_WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .SPI_SI(SPI_SI),
    .SCLK1(SCLK1), .SCLK2(SCLK2), .LAT(LAT),
    .ERR_CLR(ERR_CLR), .DATA_OUT(DATA_OUT),
    .DATA_VLD(DATA_VLD), .BUSY(BUSY),
    .FRAME_ERR(FRAME_ERR), .ERR_CODE(ERR_CODE)
  );

  always @(negedge CLK) begin
    if (DATA_VLD && prev_vld) vld_wide++;
    prev_vld = DATA_VLD;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic s1_pulse();
    SCLK1 = 1'b1; tick(2);
    SCLK1 = 1'b0; tick(2);
  endtask

  task automatic send_bit(input logic b);
    SPI_SI = b; tick(2);
    s1_pulse();
    SCLK2 = 1'b1; tick(2);
    SCLK2 = 1'b0; tick(2);
  endtask

  task automatic send_bits(input logic [31:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  // LAT pulse (optionally with coincident SCLK2 rise); reports the
  // negedge index of the first DATA_VLD and the number of high samples.
  task automatic lat_pulse(input logic with_s2, output int a, output int n);
    a = 0;
    n = 0;
    LAT = 1'b1;
    if (with_s2) SCLK2 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      if (DATA_VLD) begin
        n++;
        if (a == 0) a = i;
      end
      if (i == 3) begin
        LAT   = 1'b0;
        SCLK2 = 1'b0;
      end
    end
  endtask

  task automatic clear_err();
    ERR_CLR = 1'b1; tick(1);
    ERR_CLR = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; SPI_SI = 1'b0; SCLK1 = 1'b0;
    SCLK2 = 1'b0; LAT = 1'b0; ERR_CLR = 1'b0;
    tick(3);
    checks++;
    if ({DATA_OUT, DATA_VLD, BUSY, FRAME_ERR, ERR_CODE} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h/%b/%b/%b/%b want 0",
               DATA_OUT, DATA_VLD, BUSY, FRAME_ERR, ERR_CODE);
    end
    RST_N = 1'b1; tick(2);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", BUSY);
    end
  endtask

  task automatic test_good();
    send_bits(32'hA5, 8);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL good_busy_mid: got %b want 1", BUSY);
    end
    send_bits(32'hC3, 8);
    lat_pulse(1'b0, at, nv);
    checks++;
    if (at !== EXP_LAT) begin
      errors++; $display("FAIL good_vld_lat: got %0d want %0d", at, EXP_LAT);
    end
    checks++;
    if (nv !== 1) begin
      errors++; $display("FAIL good_vld_count: got %0d want 1", nv);
    end
    checks++;
    if (DATA_OUT !== 16'hA5C3) begin
      errors++; $display("FAIL good_data: got %h want a5c3", DATA_OUT);
    end
    checks++;
    if (FRAME_ERR !== 1'b0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL good_flags: got err=%b busy=%b want 0/0", FRAME_ERR, BUSY);
    end
  endtask

  task automatic test_length();
    send_bits(32'h1234, 15);
    lat_pulse(1'b0, at, nv);
    checks++;
    if (nv !== 0) begin
      errors++; $display("FAIL len15_vld: got %0d pulses want 0", nv);
    end
    checks++;
    if (FRAME_ERR !== 1'b1 || ERR_CODE !== 2'b01) begin
      errors++;
      $display("FAIL len15_err: got %b/%b want 1/01", FRAME_ERR, ERR_CODE);
    end
    checks++;
    if (DATA_OUT !== 16'hA5C3) begin
      errors++; $display("FAIL len15_hold: got %h want a5c3", DATA_OUT);
    end
    send_bits(32'h12345, 17);
    lat_pulse(1'b0, at, nv);
    checks++;
    if (nv !== 0) begin
      errors++; $display("FAIL len17_vld: got %0d pulses want 0", nv);
    end
    checks++;
    if (ERR_CODE !== 2'b01 || DATA_OUT !== 16'hA5C3) begin
      errors++;
      $display("FAIL len17_hold: got code=%b data=%h want 01/a5c3",
               ERR_CODE, DATA_OUT);
    end
    clear_err();
    checks++;
    if (FRAME_ERR !== 1'b0 || ERR_CODE !== 2'b00) begin
      errors++;
      $display("FAIL len_clear: got %b/%b want 0/00", FRAME_ERR, ERR_CODE);
    end
  endtask

  task automatic test_phase();
    SPI_SI = 1'b1; tick(2);
    s1_pulse();
    s1_pulse();
    tick(2);
    checks++;
    if (FRAME_ERR !== 1'b1 || ERR_CODE !== 2'b10) begin
      errors++;
      $display("FAIL phase_err: got %b/%b want 1/10", FRAME_ERR, ERR_CODE);
    end
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL phase_drop_busy: got %b want 1", BUSY);
    end
    lat_pulse(1'b0, at, nv);
    checks++;
    if (nv !== 0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL phase_drop_lat: got vld=%0d busy=%b want 0/0", nv, BUSY);
    end
    send_bits(32'h1234, 16);
    lat_pulse(1'b0, at, nv);
    checks++;
    if (at !== EXP_LAT || DATA_OUT !== 16'h1234) begin
      errors++;
      $display("FAIL phase_recover: got at=%0d data=%h want %0d/1234",
               at, DATA_OUT, EXP_LAT);
    end
    checks++;
    if (ERR_CODE !== 2'b10) begin
      errors++; $display("FAIL phase_sticky: got %b want 10", ERR_CODE);
    end
  endtask

  task automatic test_overlap();
    clear_err();
    SCLK1 = 1'b1; tick(1);
    SCLK2 = 1'b1; tick(1);
    SCLK1 = 1'b0; tick(1);
    SCLK2 = 1'b0; tick(4);
    checks++;
    if (FRAME_ERR !== 1'b1 || ERR_CODE !== 2'b11) begin
      errors++;
      $display("FAIL ovlp_err: got %b/%b want 1/11", FRAME_ERR, ERR_CODE);
    end
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL ovlp_busy: got %b want 1", BUSY);
    end
    clear_err();
    checks++;
    if (FRAME_ERR !== 1'b0 || ERR_CODE !== 2'b00) begin
      errors++;
      $display("FAIL ovlp_clear: got %b/%b want 0/00", FRAME_ERR, ERR_CODE);
    end
    lat_pulse(1'b0, at, nv);
    checks++;
    if (nv !== 0 || BUSY !== 1'b0 || DATA_OUT !== 16'h1234) begin
      errors++;
      $display("FAIL ovlp_lat: got vld=%0d busy=%b data=%h want 0/0/1234",
               nv, BUSY, DATA_OUT);
    end
  endtask

  task automatic test_back_to_back();
    send_bits(32'hFFFF, 15);
    SPI_SI = 1'b1; tick(2);
    s1_pulse();
    lat_pulse(1'b1, at, nv);
    checks++;
    if (at !== EXP_LAT || nv !== 1) begin
      errors++;
      $display("FAIL coinc_vld: got at=%0d n=%0d want %0d/1", at, nv, EXP_LAT);
    end
    checks++;
    if (DATA_OUT !== 16'hFFFF || FRAME_ERR !== 1'b0) begin
      errors++;
      $display("FAIL coinc_data: got %h err=%b want ffff/0", DATA_OUT, FRAME_ERR);
    end
  endtask

  task automatic test_reset_midframe();
    send_bits(32'hAA, 8);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++; $display("FAIL rst_mid_busy: got %b want 1", BUSY);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({DATA_OUT, DATA_VLD, BUSY, FRAME_ERR, ERR_CODE} !== 21'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %h/%b/%b/%b/%b want 0",
               DATA_OUT, DATA_VLD, BUSY, FRAME_ERR, ERR_CODE);
    end
    tick(2);
    RST_N = 1'b1; tick(2);
    send_bits(32'h0001, 16);
    lat_pulse(1'b0, at, nv);
    checks++;
    if (at !== EXP_LAT || DATA_OUT !== 16'h0001) begin
      errors++;
      $display("FAIL rst_recover: got at=%0d data=%h want %0d/0001",
               at, DATA_OUT, EXP_LAT);
    end
    checks++;
    if (FRAME_ERR !== 1'b0) begin
      errors++; $display("FAIL rst_recover_err: got %b want 0", FRAME_ERR);
    end
  endtask

  task automatic test_vld_width();
    checks++;
    if (vld_wide !== 0) begin
      errors++; $display("FAIL vld_width: got %0d wide pulses want 0", vld_wide);
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_length();
    test_phase();
    test_overlap();
    test_back_to_back();
    test_reset_midframe();
    test_vld_width();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scpu_spi_rx.md
# scpu_spi_rx

Receive end of the SCPU analog-configuration serial link: deserializes the two-phase, latch-terminated stream (SPI_SO, SCLK1, SCLK2, LAT) that the SCPU controller drives, and presents each completed word as a parallel register. Used on the analog-side test die and in the top-level bench as the link checker. Oversamples all link inputs on the local system clock and checks frame length and clock-phase ordering.

## Interface
- DATA_WIDTH, 16, bits per frame (MSB first)
- CLK  input  1  system clock, rising edge; all link inputs sampled on it
- RST_N  input  1  reset, asynchronous assert, active-low
- SPI_SI  input  1  serial data (from SPI_SO)
- SCLK1  input  1  phase-1 clock: rising edge captures SPI_SI into master bit
- SCLK2  input  1  phase-2 clock: rising edge shifts master bit into shift register
- LAT  input  1  rising edge terminates frame
- ERR_CLR  input  1  synchronous clear of FRAME_ERR/ERR_CODE
- DATA_OUT  output  DATA_WIDTH  last good word; reset 0
- DATA_VLD  output  1  one-cycle pulse on DATA_OUT update; reset 0
- BUSY  output  1  frame in progress (state != IDLE); reset 0
- FRAME_ERR  output  1  sticky error flag; reset 0
- ERR_CODE  output  2  first error since clear: 00 none, 01 length, 10 phase, 11 overlap; reset 00

## Operation
- Each of SCLK1, SCLK2, LAT registered (r1) and delayed (r2); rise = r1 & ~r2. SPI_SI sampled alongside SCLK1.
- States: IDLE (count 0, no master bit), CAP (master bit held), SHF (≥1 bit shifted, awaiting SCLK1 or LAT), DROP (frame poisoned, waiting LAT).
- IDLE/SHF + SCLK1 rise -> master <= SPI_SI, CAP.
- CAP + SCLK2 rise -> shift <= {shift[DATA_WIDTH-2:0], master}; count++ saturating at DATA_WIDTH+1; SHF.
- Phase error (code 10) -> DROP: SCLK1 rise in CAP; SCLK2 rise in IDLE/SHF.
- Overlap error (code 11) -> DROP: SCLK1 and SCLK2 sampled high in same cycle, any state except DROP.
- LAT rise in SHF: count == DATA_WIDTH -> DATA_OUT <= shift, DATA_VLD pulse; otherwise length error (01). Always -> IDLE, count 0.
- LAT rise in IDLE: ignored, no error. In CAP: length error (01), -> IDLE. In DROP: -> IDLE, no DATA_VLD.
- More than DATA_WIDTH shifts: oldest bits drop off MSB, count saturates, LAT reports length error.
- FRAME_ERR set on any error; ERR_CODE written only when FRAME_ERR is 0 (first error held). ERR_CLR clears both; error in same cycle as ERR_CLR wins (flag set, code written).
- Same-cycle SCLK2 rise and LAT rise: shift applied first, LAT evaluated on post-shift count/data.
- DATA_OUT holds across errors; changes only on good frame.

## Timing
- Latency: event sampled high at CLK edge k -> state/outputs update at edge k+1 (k+3 with SYNC_EN).
- DATA_VLD high exactly one cycle.
- Every SCLK1/SCLK2/LAT high and low phase ≥ 2 CLK periods; SPI_SI stable from 1 CLK before SCLK1 rise until 1 CLK after.
- RST_N assertion mid-frame: immediate return to IDLE, all outputs to reset values, partial frame discarded.

## Configuration
- SCPU_SPI_RX_SYNC_EN defined: two-flop synchronizer ahead of r1 on all four link inputs; +2 cycles latency; for asynchronous link clocks across dies.
- Undefined: single sampling register; link must be synchronous to CLK.

## Structure
- Package scpu_spi_rx_pkg: state encoding (IDLE, CAP, SHF, DROP), ERR_CODE constants (NONE, LEN, PHASE, OVLP).
- Sub-module scpu_spi_rx_edge: optional synchronizer + r1/r2 + rise output, one instance per link input (SCLK1, SCLK2, LAT; SPI_SI uses level only).

## Test plan
- 16 clean bits 0xA5C3 then LAT -> DATA_OUT=0xA5C3, DATA_VLD one cycle, FRAME_ERR=0, BUSY low after.
- 15 bits then LAT -> ERR_CODE=01, DATA_OUT keeps previous 0xA5C3; 17 bits then LAT -> ERR_CODE stays 01 (first held), no DATA_VLD.
- Two SCLK1 pulses without SCLK2 -> ERR_CODE=10, DROP; next LAT -> IDLE, no DATA_VLD; following clean 0x1234 frame -> DATA_VLD, DATA_OUT=0x1234.
- SCLK1 and SCLK2 overlapped high one cycle -> ERR_CODE=11; ERR_CLR pulse -> FRAME_ERR=0, ERR_CODE=00.
- 16th SCLK2 rise coincident with LAT rise, data 0xFFFF -> DATA_OUT=0xFFFF, no error.
- RST_N low after 8 bits -> all outputs 0, state IDLE; clean 0x0001 frame afterward -> DATA_OUT=0x0001; repeat with SCPU_SPI_RX_SYNC_EN, checking DATA_VLD 2 cycles later.
